// File: rtl/sdnet_to_mtpsa_pkg.sv
// Shared definitions for the SDNet <-> MTPSA adapters: tuple widths, SUME tuser
// field offsets and the egress FSM state encoding.
package sdnet_mtpsa_pkg;

   localparam int unsigned META_KEEP_WIDTH = 48;
   localparam int unsigned DIGEST_WIDTH    = 256;

   // Bit offsets within the SUME-format tuser {digest, metadata[47:0]}
   localparam int unsigned PKT_LEN_LSB  = 0;
   localparam int unsigned PKT_LEN_W    = 16;
   localparam int unsigned SRC_PORT_LSB = 16;
   localparam int unsigned DST_PORT_LSB = 24;
   localparam int unsigned SEND_DIG_LSB = 32;
   localparam int unsigned USER_ID_LSB  = 40;
   localparam int unsigned FIELD8_W     = 8;
   localparam int unsigned DIGEST_LSB   = META_KEEP_WIDTH;

   localparam logic [0:0] ST_FIRST = 1'b0;
   localparam logic [0:0] ST_BODY  = 1'b1;

endpackage

// File: rtl/sdnet_to_mtpsa_tuple_fifo.sv
// Small synchronous FIFO with a combinational head; the caller only pushes
// while full when a pop is taken in the same cycle.
module tuple_fifo #(
   parameter int unsigned WIDTH = 304,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sdnet_to_mtpsa.sv
// Egress adapter: queues SDNet output tuples and re-attaches each one as SUME
// tuser on the first beat of its packet, stalling packets that outrun their tuple.
module sdnet_to_mtpsa
   import sdnet_mtpsa_pkg::*;
#(
   parameter int unsigned C_AXIS_DATA_WIDTH    = 256,
   parameter int unsigned C_TUPLE_WIDTH        = 128,
   parameter int unsigned DIGEST_WIDTH         = sdnet_mtpsa_pkg::DIGEST_WIDTH,
   parameter int unsigned META_KEEP_WIDTH      = sdnet_mtpsa_pkg::META_KEEP_WIDTH,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 304,
   parameter int unsigned TUPLE_FIFO_DEPTH     = 4
) (
   input  logic                              axis_aclk,
   input  logic                              axis_rst,
   input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   input  logic                              tuple_meta_valid,
   input  logic [C_TUPLE_WIDTH-1:0]          tuple_meta_data,
   input  logic                              tuple_digest_valid,
   input  logic [DIGEST_WIDTH-1:0]           tuple_digest_data,
   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic                              tuple_overflow,
   output logic [15:0]                       tuple_drop_count,
   output logic [15:0]                       valid_mismatch_count,
   output logic [31:0]                       pkt_count
);

   logic [0:0]                      state;
   logic [0:0]                      state_nx;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] entry;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] head;
   logic                            full;
   logic                            empty;
   logic                            gate;
   logic                            hs;
   logic                            push;
   logic                            pop;
   logic                            drop;
   logic                            unused_meta;

   // Only the low metadata fields travel downstream
   assign unused_meta = ^tuple_meta_data[C_TUPLE_WIDTH-1:META_KEEP_WIDTH];

   assign entry = {(tuple_digest_valid ? tuple_digest_data : {DIGEST_WIDTH{1'b0}}),
                   tuple_meta_data[META_KEEP_WIDTH-1:0]};

   // A packet may start only once its tuple is at the FIFO head
   assign gate          = (state == ST_BODY) || !empty;
   assign m_axis_tvalid = s_axis_tvalid && gate;
   assign s_axis_tready = m_axis_tready && gate;
   assign hs            = s_axis_tvalid && s_axis_tready;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tuser  = (state == ST_FIRST) ? head : {C_M_AXIS_TUSER_WIDTH{1'b0}};

   assign pop  = hs && (state == ST_FIRST);
   assign push = tuple_meta_valid && (!full || pop);
   assign drop = tuple_meta_valid && full && !pop;

   tuple_fifo #(
      .WIDTH (C_M_AXIS_TUSER_WIDTH),
      .DEPTH (TUPLE_FIFO_DEPTH)
   ) u_tuple_fifo (
      .clk   (axis_aclk),
      .rst   (axis_rst),
      .push  (push),
      .pop   (pop),
      .din   (entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_nx = state;
      if (hs) begin
         if (state == ST_FIRST) begin
            if (!s_axis_tlast) state_nx = ST_BODY;
         end else if (s_axis_tlast) begin
            state_nx = ST_FIRST;
         end
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_rst) state <= ST_FIRST;
      else          state <= state_nx;
   end

   // Debug counters: drop/mismatch saturate, packet count wraps
   always_ff @(posedge axis_aclk) begin
      if (axis_rst) begin
         tuple_overflow       <= 1'b0;
         tuple_drop_count     <= 16'd0;
         valid_mismatch_count <= 16'd0;
         pkt_count            <= 32'd0;
      end else begin
         if (drop) begin
            tuple_overflow <= 1'b1;
            if (tuple_drop_count != 16'hFFFF) tuple_drop_count <= tuple_drop_count + 16'd1;
         end
         if ((tuple_meta_valid ^ tuple_digest_valid) && (valid_mismatch_count != 16'hFFFF))
            valid_mismatch_count <= valid_mismatch_count + 16'd1;
         if (hs && s_axis_tlast) pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule

// File: doc/sdnet_to_mtpsa.md
Name: sdnet_to_mtpsa

Overview:
- Egress-side adapter after the suIngressSwitch SDNet core. The inverse of mtpsa_to_sdnet.
- Captures each SDNet output tuple (mtpsa metadata plus digest) into a small tuple FIFO.
- Re-attaches the tuple to the matching packet's first AXIS beat as SUME-format tuser ({digest, metadata[47:0]}).
- Stalls any packet whose tuple has not yet arrived, and counts tuple overflow and valid-mismatch events for debug.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
- C_TUPLE_WIDTH, 128, width of SDNet mtpsa metadata tuple.
- DIGEST_WIDTH, 256, width of SDNet digest tuple.
- META_KEEP_WIDTH, 48, low metadata bits forwarded (pkt_len, src_port, dst_port, send_dig, user_id).
- C_M_AXIS_TUSER_WIDTH, 304, equals DIGEST_WIDTH+META_KEEP_WIDTH.
- TUPLE_FIFO_DEPTH, 4, tuple FIFO entries; power of two, at least 2.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  SDNet packet_out data.
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  SDNet packet_out keep.
- s_axis_tvalid  in  1  SDNet packet_out valid.
- s_axis_tready  out  1  to SDNet packet_out ready.
- s_axis_tlast  in  1  SDNet packet_out last.
- tuple_meta_valid  in  1  SDNet tuple_out_mtpsa_metadata_VALID; one-cycle pulse per packet.
- tuple_meta_data  in  C_TUPLE_WIDTH  SDNet metadata tuple.
- tuple_digest_valid  in  1  SDNet tuple_out_digest_data_VALID.
- tuple_digest_data  in  DIGEST_WIDTH  SDNet digest tuple.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  SUME output data.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  SUME output keep.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  SUME output tuser.
- m_axis_tvalid  out  1  SUME output valid.
- m_axis_tready  in  1  SUME output ready.
- m_axis_tlast  out  1  SUME output last.
- tuple_overflow  out  1  sticky: a tuple was dropped because the FIFO was full.
- tuple_drop_count  out  16  tuples dropped; saturates at 0xFFFF.
- valid_mismatch_count  out  16  cycles where meta/digest valids differ; saturates at 0xFFFF.
- pkt_count  out  32  packets completed on m_axis; wraps.

Behaviour:
- Reset (sync, axis_rst=1):
  - FIFO emptied, FSM to FIRST.
  - tuple_overflow=0; all counters=0.
  - m_axis_tvalid=0, s_axis_tready=0; m_axis_tuser/tdata are don't-care while tvalid=0.
  - Reset mid-packet abandons the packet. Upstream SDNet is reset concurrently.
- Tuple capture:
  - When tuple_meta_valid=1, entry = {tuple_digest_valid ? tuple_digest_data : 0, tuple_meta_data[META_KEEP_WIDTH-1:0]}.
  - The entry is written at the clock edge and is visible at the FIFO head no earlier than the next cycle (no bypass).
- Valid mismatch: tuple_meta_valid XOR tuple_digest_valid increments valid_mismatch_count. A digest_valid arriving without meta_valid is otherwise ignored.
- FIFO pointers: log2(DEPTH)+1 bits; wrap naturally.
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.
- Push when full:
  - If a pop occurs the same cycle, the push is accepted.
  - Otherwise the tuple is dropped, tuple_overflow is set, and tuple_drop_count increments.
- FSM with states FIRST and BODY:
  - gate = (state==BODY) || !empty.
  - m_axis_tvalid = s_axis_tvalid && gate.
  - s_axis_tready = m_axis_tready && gate (combinational path; zero-latency data path).
  - tdata, tkeep and tlast pass straight through.
  - m_axis_tuser = FIFO head in FIRST, all-zero in BODY.
  - Handshake: s_axis_tvalid && s_axis_tready.
  - FIRST, handshake, tlast=0: pop, go to BODY.
  - FIRST, handshake, tlast=1: pop, stay FIRST, pkt_count++ (single-beat packet).
  - BODY, handshake, tlast=1: go to FIRST, pkt_count++.
  - Packet arriving with FIFO empty: holds in FIRST with s_axis_tready=0 and m_axis_tvalid=0 until a tuple is present.
- AXIS rules:
  - Once m_axis_tvalid is asserted, it and its data are stable until m_axis_tready, which holds because the s-side is stalled identically.
  - No beat is ever dropped or duplicated.

Decomposition:
- Shared package sdnet_mtpsa_pkg holds:
  - META_KEEP_WIDTH and DIGEST_WIDTH defaults.
  - tuser field offsets (PKT_LEN, SRC_PORT, DST_PORT, SEND_DIG, USER_ID, DIGEST).
  - FSM state encoding.
- Sub-module tuple_fifo: synchronous FIFO with width and depth parameters, providing push, pop, head, full and empty.

Test Plan:
- Tuple meta=0x..00AA_0102_0040 with digest=0x1234 one cycle before a 3-beat packet, m_axis_tready=1 -> beat0 tuser={0x1234, 0x00AA01020040}; beats 1-2 tuser=0; pkt_count=1.
- 2-beat packet presented 5 cycles before its tuple -> s_axis_tready=0 and m_axis_tvalid=0 for those cycles; beat0 leaves the cycle after the tuple write.
- 6 back-to-back tuples, no packets, DEPTH=4 -> tuple_drop_count=2 and tuple_overflow=1; 4 subsequent packets carry tuples 1-4 in order.
- Single-beat packets with m_axis_tready toggling 1010 -> each beat output exactly once, tuser held stable while stalled; pkt_count equals packet count.
- meta_valid without digest_valid -> tuser digest field=0; valid_mismatch_count=1.
- Assert axis_rst mid-packet (beat 2 of 4) -> next cycle m_axis_tvalid=0, counters=0, FIFO empty, FSM=FIRST.
